// File: rtl/snn_ecg_classifier.sv
// Spike-count classifier: accumulates per-class output spikes over a window and reports the argmax.
// Optional reject of low-confidence winners with macro SNN_CLS_REJECT_EN.
module snn_ecg_classifier #(
    parameter int unsigned N_CLS     = 5,
    parameter int unsigned TSTEPS    = 64,
    parameter int unsigned CNT_W     = 7,
    parameter int unsigned MIN_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             snn_done,
    input  logic [N_CLS-1:0] spikes_out_bits,
    output logic             class_valid,
    output logic [2:0]       class_id,
    output logic [CNT_W-1:0] class_count,
    output logic [6:0]       step_idx,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned      IDX_W     = 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_COUNT);
    localparam logic [6:0]       STEP_LAST = 7'(TSTEPS);
    localparam logic [6:0]       STEP_PRE  = 7'(TSTEPS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CLS - 1);
    localparam logic [2:0]       REJECT_ID = 3'b111;
`ifdef SNN_CLS_REJECT_EN
    localparam bit REJECT_EN = 1'b1;
`else
    localparam bit REJECT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, REPORT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_CLS];
    logic [CNT_W-1:0] cnt_d [N_CLS];
    logic [6:0]       step_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0] best_id_q, best_id_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [CNT_W-1:0] cand;
    logic [IDX_W-1:0] win_id;
    logic [CNT_W-1:0] win_cnt;
    logic             valid_d, busy_d, overrun_d;
    logic [2:0]       id_d;
    logic [CNT_W-1:0] count_d;

    // Next-state and datapath; frame_start overrides every state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_idx;
        scan_d     = scan_q;
        best_id_d  = best_id_q;
        best_cnt_d = best_cnt_q;
        valid_d    = 1'b0;
        id_d       = class_id;
        count_d    = class_count;
        overrun_d  = overrun;
        cand       = '0;
        for (int unsigned i = 0; i < N_CLS; i++) begin
            if (scan_q == IDX_W'(i)) cand = cnt_q[i];
        end
        win_id  = best_id_q;
        win_cnt = best_cnt_q;
        // First class seeds the best; later ones replace it only when strictly greater
        if (scan_q == '0 || cand > best_cnt_q) begin
            win_id  = scan_q;
            win_cnt = cand;
        end

        if (frame_start) begin
            state_d   = ACCUM;
            step_d    = '0;
            scan_d    = '0;
            overrun_d = 1'b0;
            for (int unsigned i = 0; i < N_CLS; i++) cnt_d[i] = '0;
            if (snn_done) begin
                for (int unsigned i = 0; i < N_CLS; i++) cnt_d[i] = CNT_W'(spikes_out_bits[i]);
                step_d = 7'd1;
                if (STEP_LAST == 7'd1) state_d = ARGMAX;
            end
        end else begin
            case (state_q)
                ACCUM: begin
                    if (snn_done) begin
                        for (int unsigned i = 0; i < N_CLS; i++) begin
                            if (spikes_out_bits[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                        if (step_idx != STEP_LAST) step_d = step_idx + 7'd1;
                        if (step_idx == STEP_PRE) begin
                            state_d = ARGMAX;
                            scan_d  = '0;
                        end
                    end
                end
                ARGMAX: begin
                    best_id_d  = win_id;
                    best_cnt_d = win_cnt;
                    scan_d     = scan_q + IDX_W'(1);
                    if (scan_q == IDX_LAST) begin
                        state_d = REPORT;
                        valid_d = 1'b1;
                        count_d = win_cnt;
                        id_d    = (REJECT_EN && win_cnt < CNT_MIN) ? REJECT_ID : win_id;
                    end
                end
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (snn_done && state_q != ACCUM) overrun_d = 1'b1;
        end
        busy_d = (state_d == ACCUM) || (state_d == ARGMAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < N_CLS; i++) cnt_q[i] <= '0;
            step_idx    <= '0;
            scan_q      <= '0;
            best_id_q   <= '0;
            best_cnt_q  <= '0;
            class_valid <= 1'b0;
            class_id    <= '0;
            class_count <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_idx    <= step_d;
            scan_q      <= scan_d;
            best_id_q   <= best_id_d;
            best_cnt_q  <= best_cnt_d;
            class_valid <= valid_d;
            class_id    <= id_d;
            class_count <= count_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_snn_ecg_classifier.sv
// Self-checking bench for snn_ecg_classifier against a window-level behavioural model.
module tb_snn_ecg_classifier;

    localparam int N   = 5;
    localparam int T   = 64;
    localparam int MIN = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         snn_done;
    logic [N-1:0] spikes_out_bits;
    logic         class_valid;
    logic [2:0]   class_id;
    logic [6:0]   class_count;
    logic [6:0]   step_idx;
    logic         busy;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    // Model: counts, step count, accumulating flag, cycles until result is due
    int m_cnt [N];
    int m_steps, m_pend, r_id, r_cnt;
    bit m_acc, m_valid, m_ovr;
    int m_id, m_count;

    snn_ecg_classifier dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .snn_done(snn_done),
        .spikes_out_bits(spikes_out_bits), .class_valid(class_valid), .class_id(class_id),
        .class_count(class_count), .step_idx(step_idx), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_steps = 0; m_pend = 0; m_acc = 0; m_valid = 0; m_ovr = 0;
        m_id = 0; m_count = 0; r_id = 0; r_cnt = 0;
    endtask

    task automatic finish_window();
        int best;
        best = -1;
        for (int i = 0; i < N; i++) begin
            if (m_cnt[i] > best) begin
                best = m_cnt[i];
                r_id = i;
            end
        end
        r_cnt = best;
`ifdef SNN_CLS_REJECT_EN
        if (r_cnt < MIN) r_id = 7;
`endif
        m_acc  = 0;
        m_pend = N;
    endtask

    task automatic model_update(input logic fs, input logic sd, input logic [N-1:0] b);
        m_valid = 0;
        if (fs) begin
            for (int i = 0; i < N; i++) m_cnt[i] = (sd && b[i]) ? 1 : 0;
            m_steps = sd ? 1 : 0;
            m_ovr = 0; m_pend = 0; m_acc = 1;
            if (m_steps == T) finish_window();
        end else begin
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_valid = 1; m_id = r_id; m_count = r_cnt;
                end
            end
            if (sd) begin
                if (m_acc) begin
                    for (int i = 0; i < N; i++) if (b[i] && m_cnt[i] < 127) m_cnt[i]++;
                    m_steps++;
                    if (m_steps == T) finish_window();
                end else begin
                    m_ovr = 1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("class_valid", int'(class_valid), int'(m_valid));
        chk("class_id",    int'(class_id),    m_id);
        chk("class_count", int'(class_count), m_count);
        chk("step_idx",    int'(step_idx),    m_steps);
        chk("busy",        int'(busy),        int'(m_acc || m_pend > 0));
        chk("overrun",     int'(overrun),     int'(m_ovr));
    endtask

    // Called at a falling edge: drive, let the rising edge sample, then compare
    task automatic step(input logic fs, input logic sd, input logic [N-1:0] b);
        frame_start = fs; snn_done = sd; spikes_out_bits = b;
        @(posedge clk);
        #1 model_update(fs, sd, b);
        @(negedge clk);
        compare();
    endtask

    function automatic logic [N-1:0] pat(input int mode, input int s);
        case (mode)
            0:       return 5'b00100;
            1:       return (s < 30) ? 5'b01010 : 5'b00000;
            3:       return (s < 10) ? 5'b10000 : 5'b00000;
            default: return 5'b00000;
        endcase
    endfunction

    // Directed window: optional prefix of pre steps, restarted by frame_start
    task automatic window(input int mode, input int pre, input int exp_id, input int exp_cnt,
                          input string name);
        int lat, pulses, got_id, got_cnt;
        step(1'b1, 1'b0, '0);
        if (pre > 0) begin
            for (int s = 0; s < pre; s++) step(1'b0, 1'b1, 5'b00001);
            step(1'b1, 1'b0, '0);
            chk({name, "_restart_step"}, int'(step_idx), 0);
        end
        for (int s = 0; s < T; s++) begin
            if (s > 0) step(1'b0, 1'b0, '0);
            step(1'b0, 1'b1, pat(mode, s));
        end
        lat = -1; pulses = 0; got_id = -1; got_cnt = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, '0);
            if (class_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; got_id = int'(class_id); got_cnt = int'(class_count);
                end
            end
        end
        chk({name, "_latency"}, lat, 5);
        chk({name, "_pulses"}, pulses, 1);
        chk({name, "_id"}, got_id, exp_id);
        chk({name, "_count"}, got_cnt, exp_cnt);
    endtask

    initial begin
        frame_start = 1'b0; snn_done = 1'b0; spikes_out_bits = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        compare();
        rst = 1'b0;
        step(1'b0, 1'b0, '0);

        window(0, 0, 2, 64, "single_class");
        window(1, 0, 1, 30, "tie");
`ifdef SNN_CLS_REJECT_EN
        window(2, 0, 7, 0, "all_zero");
`else
        window(2, 0, 0, 0, "all_zero");
`endif
        window(3, 40, 4, 10, "restart");

        // Stray snn_done in IDLE, then a fresh frame clears overrun
        step(1'b0, 1'b1, 5'b11111);
        chk("idle_overrun_set", int'(overrun), 1);
        chk("idle_step_hold", int'(step_idx), 64);
        step(1'b1, 1'b0, '0);
        chk("overrun_cleared", int'(overrun), 0);

        // Reset in the middle of ARGMAX
        for (int s = 0; s < T; s++) step(1'b0, 1'b1, 5'b00010);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_step", int'(step_idx), 0);
        compare();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0);

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            logic fs, sd;
            logic [N-1:0] b;
            if (!m_acc && m_pend == 0) fs = ($urandom_range(0, 7) == 0);
            else                       fs = ($urandom_range(0, 299) == 0);
            sd = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 99) < 10 + 15 * i);
            step(fs, sd, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
